rv64g_l2_a_arbiter: RTL and testbench
=====================================

// Module: rv64g_l2_a_arbiter
// PURPOSE
// - Upstream of the L2 cache: merges CORES per-core L1 TileLink A channels into the single L2 A sink.
// - Round-robin arbitration, one-entry output register stage.
// - Tags the forwarded source with the core ID so D-channel grants can be routed back.
// - Full throughput: one A beat per cycle when downstream is ready.
// PARAMETERS
// - CORES     4   number of L1 requestors (>=1)
// - ADDR_W    64  address width
// - SOURCE_W  6   L2-side source width
// - CID_W     2   core-ID bits placed in source MSBs; LSRC_W = SOURCE_W-CID_W = per-core source width
// PORTS
// - clk_i           in   1                 clock
// - rst_i           in   1                 synchronous reset, active-high
// - core_a_opcode_i in   CORES*3           per-core opcode, core k at [3k+:3]
// - core_a_param_i  in   CORES*3           per-core param
// - core_a_source_i in   CORES*LSRC_W      per-core local source
// - core_a_address_i in  CORES*ADDR_W      per-core address
// - core_a_valid_i  in   CORES             per-core valid
// - core_a_ready_o  out  CORES             per-core ready (one-hot or zero)
// - tl_a_opcode_o   out  3                 to L2 A opcode
// - tl_a_param_o    out  3                 to L2 A param
// - tl_a_source_o   out  SOURCE_W          {core_id[CID_W-1:0], local_source}
// - tl_a_address_o  out  ADDR_W            to L2 A address
// - tl_a_valid_o    out  1                 to L2 A valid
// - tl_a_ready_i    in   1                 from L2 A ready
// BEHAVIOUR
// - One clock domain. Reset is synchronous, active-high, on clk_i rising edge.
// - Reset values:
//   - tl_a_valid_o=0; opcode/param/source/address=0; rr pointer=0.
//   - core_a_ready_o=0 in every cycle rst_i is high.
// - load_en = !out_valid | tl_a_ready_i (combinational).
// - Grant: among core_a_valid_i, pick first index >= ptr, wrapping modulo CORES.
//   - core_a_ready_o[g] = load_en & valid[g] & !rst_i. All other readies are 0.
// - On a handshake with core g:
//   - Register fields, source = {g, core_a_source[g]}.
//   - Set out_valid. Set ptr = (g+1) mod CORES.
// - Latency: 1 cycle, core handshake -> tl_a_valid_o.
// - Back-to-back: a beat accepted while the previous beat drains (tl_a_ready_i=1) gives no bubble.
// - No grant: ptr unchanged. out_valid clears when tl_a_ready_i=1 and nothing loads.
// - While tl_a_valid_o=1 and tl_a_ready_i=0, all outputs are held stable (TileLink rule).
// - Core-ready does not depend on tl_a_ready_i when the register is empty.
// - ptr wrap: CORES not a power of two wraps explicitly at CORES-1 -> 0.
// - CORES=1 degenerates to a pipeline register with tag 0.
// - Reset mid-operation drops the buffered beat: tl_a_valid_o=0 on the next cycle, ptr=0.
// - Elaboration error when CID_W < $clog2(CORES) or LSRC_W < 1.
// - Opcodes are forwarded unchanged; no legality checks.
// STRUCTURE
// - rv64g_l2_pkg: TL A opcode constants (PutFullData=0, Get=4, AcquireBlock=6, AcquirePerm=7).
//   Also the tl_a_beat_t struct (opcode, param, source, address) and the LSRC_W derivation.
// - Sub-module rv64g_rr_arbiter #(N): req[N], advance -> gnt one-hot, gnt_idx; owns ptr.
// - Top: holds the output register, source tagging and field muxing.
// TESTING
// - Single request:
//   - Stimulus: core2 Get, src=5, addr=0x1000, tl_a_ready_i=1.
//   - Response: core_a_ready_o=4'b0100 in cycle 0; cycle 1 tl_a_valid_o=1, source=6'h25, opcode=4.
// - All four cores valid continuously, downstream always ready.
//   - Response: grants in order 0,1,2,3,0; one beat per cycle, no bubbles.
// - Backpressure:
//   - Stimulus: tl_a_ready_i=0 for 5 cycles with beat from core1 held.
//   - Response: outputs stable, core_a_ready_o=0.
//   - On release: the beat drains and a new grant is taken in the same cycle.
// - Fairness:
//   - Stimulus: core0 and core3 both valid with ptr=1.
//   - Response: core3 wins first, then core0; ptr goes 0 then 1.
// - Reset mid-transfer:
//   - Stimulus: rst_i=1 while tl_a_valid_o=1, tl_a_ready_i=0.
//   - Response: tl_a_valid_o=0 next cycle, no core ready during reset, first post-reset grant to core0.

Source files
------------

// File: rtl/rv64g_l2_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv64g_l2_pkg
// Description : Shared TileLink A-channel definitions for the L2 front end.
//               Provides the A opcode encodings, the default channel widths,
//               width-derivation helpers and the packed A-beat record.
// Revision    : 1.0 - initial release
// ============================================================================
package rv64g_l2_pkg;

  // TileLink A-channel opcodes forwarded to the L2
  localparam logic [2:0] TL_A_PUT_FULL_DATA = 3'd0;
  localparam logic [2:0] TL_A_GET           = 3'd4;
  localparam logic [2:0] TL_A_ACQUIRE_BLOCK = 3'd6;
  localparam logic [2:0] TL_A_ACQUIRE_PERM  = 3'd7;

  // Default channel geometry for the four-core cluster
  localparam int TL_ADDR_W   = 64;
  localparam int TL_SOURCE_W = 6;
  localparam int TL_CID_W    = 2;

  // Per-core (L1-side) source width: the L2 source minus the core-ID tag
  function automatic int lsrc_w(input int source_w, input int cid_w);
    return source_w - cid_w;
  endfunction

  // Width of an index into n requestors; never below one bit
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // One A-channel beat at the default geometry
  typedef struct packed {
    logic [2:0]             opcode;
    logic [2:0]             param;
    logic [TL_SOURCE_W-1:0] source;
    logic [TL_ADDR_W-1:0]   address;
  } tl_a_beat_t;

endpackage : rv64g_l2_pkg
`default_nettype wire

// File: rtl/rv64g_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rv64g_rr_arbiter
// Description : Round-robin arbiter. Grants the first requesting index at or
//               after the rotating pointer, wrapping modulo N. The pointer
//               moves to one past the winner only when the caller reports
//               that the grant was consumed (advance).
// Ports       : clk_i, rst_i   clock, synchronous active-high reset
//               req     [N]    request vector
//               advance        grant consumed this cycle
//               gnt     [N]    one-hot grant (zero when no request)
//               gnt_idx        binary index of the granted requestor
// Revision    : 1.0 - initial release
// ============================================================================
module rv64g_rr_arbiter
  import rv64g_l2_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = idx_w(N)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  logic [IW-1:0] r_ptr;
  logic          w_found;
  int            w_slot;

  // Scan N slots starting at the pointer; the first hit wins
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    w_found = 1'b0;
    w_slot  = 0;
    for (int i = 0; i < N; i++) begin
      w_slot = int'(r_ptr) + i;
      if (w_slot >= N) begin
        w_slot = w_slot - N;
      end
      if (!w_found && req[w_slot]) begin
        w_found      = 1'b1;
        gnt[w_slot]  = 1'b1;
        gnt_idx      = IW'(w_slot);
      end
    end
  end

  // Pointer wraps explicitly so non-power-of-two N never reaches N
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ptr <= '0;
    end else if (advance) begin
      if (gnt_idx == IW'(N - 1)) begin
        r_ptr <= '0;
      end else begin
        r_ptr <= gnt_idx + 1'b1;
      end
    end
  end

endmodule : rv64g_rr_arbiter
`default_nettype wire

// File: rtl/rv64g_l2_a_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rv64g_l2_a_arbiter
// Description : Merges the TileLink A channels of CORES L1 caches into the
//               single L2 A sink. Round-robin selection feeds a one-entry
//               output register; the forwarded source carries the core ID in
//               its MSBs so D-channel responses can be routed back.
//               A new beat may load in the same cycle the held beat drains,
//               giving one beat per cycle with no bubbles.
// Ports       : clk_i, rst_i        clock, synchronous active-high reset
//               core_a_*_i          packed per-core A fields, core k at slot k
//               core_a_valid_i      per-core valid
//               core_a_ready_o      per-core ready, one-hot or zero
//               tl_a_*_o            registered A beat towards the L2
//               tl_a_valid_o        A valid towards the L2
//               tl_a_ready_i        A ready from the L2
// Revision    : 1.0 - initial release
// ============================================================================
module rv64g_l2_a_arbiter
  import rv64g_l2_pkg::*;
#(
  parameter  int CORES    = 4,
  parameter  int ADDR_W   = TL_ADDR_W,
  parameter  int SOURCE_W = TL_SOURCE_W,
  parameter  int CID_W    = TL_CID_W,
  localparam int LSRC_W   = lsrc_w(SOURCE_W, CID_W),
  localparam int IW       = idx_w(CORES)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [CORES*3-1:0]       core_a_opcode_i,
  input  logic [CORES*3-1:0]       core_a_param_i,
  input  logic [CORES*LSRC_W-1:0]  core_a_source_i,
  input  logic [CORES*ADDR_W-1:0]  core_a_address_i,
  input  logic [CORES-1:0]         core_a_valid_i,
  output logic [CORES-1:0]         core_a_ready_o,
  output logic [2:0]               tl_a_opcode_o,
  output logic [2:0]               tl_a_param_o,
  output logic [SOURCE_W-1:0]      tl_a_source_o,
  output logic [ADDR_W-1:0]        tl_a_address_o,
  output logic                     tl_a_valid_o,
  input  logic                     tl_a_ready_i
);

  // --------------------------------------------------------------------------
  // Parameter legality: the tag must be able to name every core and each
  // core must keep at least one local source bit.
  // --------------------------------------------------------------------------
  generate
    if ((CID_W < $clog2(CORES)) || (LSRC_W < 1)) begin : g_param_err
      $error("rv64g_l2_a_arbiter: CID_W too small for CORES or LSRC_W < 1");
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Signals
  // --------------------------------------------------------------------------
  logic                r_valid;
  logic [2:0]          r_opcode;
  logic [2:0]          r_param;
  logic [SOURCE_W-1:0] r_source;
  logic [ADDR_W-1:0]   r_address;

  logic                w_load_en;
  logic                w_take;
  logic [CORES-1:0]    w_gnt;
  logic [IW-1:0]       w_gnt_idx;

  logic [2:0]          w_opcode;
  logic [2:0]          w_param;
  logic [LSRC_W-1:0]   w_lsrc;
  logic [ADDR_W-1:0]   w_address;
  logic [SOURCE_W-1:0] w_source;

  // --------------------------------------------------------------------------
  // Arbitration
  // --------------------------------------------------------------------------
  rv64g_rr_arbiter #(
    .N (CORES)
  ) u_rr (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .req     (core_a_valid_i),
    .advance (w_take),
    .gnt     (w_gnt),
    .gnt_idx (w_gnt_idx)
  );

  // The register can accept when empty or when its beat leaves this cycle.
  // With the register empty this is 1 regardless of tl_a_ready_i.
  assign w_load_en = ~r_valid | tl_a_ready_i;

  // Readies are forced low throughout reset so no core believes a beat
  // was taken that the flushed register will never forward.
  assign core_a_ready_o = w_gnt & {CORES{w_load_en & ~rst_i}};
  assign w_take         = |core_a_ready_o;

  // --------------------------------------------------------------------------
  // Field selection and source tagging
  // --------------------------------------------------------------------------
  always_comb begin
    w_opcode  = core_a_opcode_i [3*int'(w_gnt_idx)      +: 3];
    w_param   = core_a_param_i  [3*int'(w_gnt_idx)      +: 3];
    w_lsrc    = core_a_source_i [LSRC_W*int'(w_gnt_idx) +: LSRC_W];
    w_address = core_a_address_i[ADDR_W*int'(w_gnt_idx) +: ADDR_W];
    w_source  = {CID_W'(w_gnt_idx), w_lsrc};
  end

  // --------------------------------------------------------------------------
  // Output register. Fields only change on a load, and a load can only
  // happen when the held beat is leaving, so a stalled beat stays stable.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_valid   <= 1'b0;
      r_opcode  <= '0;
      r_param   <= '0;
      r_source  <= '0;
      r_address <= '0;
    end else if (w_take) begin
      r_valid   <= 1'b1;
      r_opcode  <= w_opcode;
      r_param   <= w_param;
      r_source  <= w_source;
      r_address <= w_address;
    end else if (tl_a_ready_i) begin
      r_valid   <= 1'b0;
    end
  end

  assign tl_a_valid_o   = r_valid;
  assign tl_a_opcode_o  = r_opcode;
  assign tl_a_param_o   = r_param;
  assign tl_a_source_o  = r_source;
  assign tl_a_address_o = r_address;

endmodule : rv64g_l2_a_arbiter
`default_nettype wire

// File: tb/tb_rv64g_l2_a_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rv64g_l2_a_arbiter
// Description : Directed scoreboard bench for rv64g_l2_a_arbiter. Stimulus
//               pushes hand-computed beats into a queue; a monitor pops and
//               compares each beat the DUT hands to the L2.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rv64g_l2_a_arbiter;
  import rv64g_l2_pkg::*;

  localparam int CORES    = 4;
  localparam int ADDR_W   = 64;
  localparam int SOURCE_W = 6;
  localparam int CID_W    = 2;
  localparam int LSRC_W   = 4;

  logic                    clk_i = 1'b0;
  logic                    rst_i = 1'b1;
  logic [CORES*3-1:0]      core_a_opcode_i  = '0;
  logic [CORES*3-1:0]      core_a_param_i   = '0;
  logic [CORES*LSRC_W-1:0] core_a_source_i  = '0;
  logic [CORES*ADDR_W-1:0] core_a_address_i = '0;
  logic [CORES-1:0]        core_a_valid_i   = '0;
  logic [CORES-1:0]        core_a_ready_o;
  logic [2:0]              tl_a_opcode_o;
  logic [2:0]              tl_a_param_o;
  logic [SOURCE_W-1:0]     tl_a_source_o;
  logic [ADDR_W-1:0]       tl_a_address_o;
  logic                    tl_a_valid_o;
  logic                    tl_a_ready_i = 1'b0;

  int         checks   = 0;
  int         failures = 0;
  tl_a_beat_t exp_q[$];

  rv64g_l2_a_arbiter #(
    .CORES    (CORES),
    .ADDR_W   (ADDR_W),
    .SOURCE_W (SOURCE_W),
    .CID_W    (CID_W)
  ) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .core_a_opcode_i  (core_a_opcode_i),
    .core_a_param_i   (core_a_param_i),
    .core_a_source_i  (core_a_source_i),
    .core_a_address_i (core_a_address_i),
    .core_a_valid_i   (core_a_valid_i),
    .core_a_ready_o   (core_a_ready_o),
    .tl_a_opcode_o    (tl_a_opcode_o),
    .tl_a_param_o     (tl_a_param_o),
    .tl_a_source_o    (tl_a_source_o),
    .tl_a_address_o   (tl_a_address_o),
    .tl_a_valid_o     (tl_a_valid_o),
    .tl_a_ready_i     (tl_a_ready_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive_core(input int k, input logic [2:0] op, input logic [2:0] prm,
                            input logic [3:0] src, input logic [63:0] adr);
    core_a_opcode_i[3*k +: 3]                = op;
    core_a_param_i[3*k +: 3]                 = prm;
    core_a_source_i[LSRC_W*k +: LSRC_W]      = src;
    core_a_address_i[ADDR_W*k +: ADDR_W]     = adr;
  endtask

  task automatic push_exp(input logic [2:0] op, input logic [2:0] prm,
                          input logic [5:0] src, input logic [63:0] adr);
    tl_a_beat_t b;
    b.opcode  = op;
    b.param   = prm;
    b.source  = src;
    b.address = adr;
    exp_q.push_back(b);
  endtask

  // Inputs change 1 time unit after the rising edge; checks sit 1 unit later
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Monitor: a beat presented with tl_a_ready_i high is consumed at the next edge
  always @(negedge clk_i) begin
    if (!rst_i && tl_a_valid_o && tl_a_ready_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_beat: got source %0h address %0h expected none",
                 tl_a_source_o, tl_a_address_o);
      end else begin
        tl_a_beat_t b;
        b = exp_q.pop_front();
        check("beat_opcode",  64'(tl_a_opcode_o),  64'(b.opcode));
        check("beat_param",   64'(tl_a_param_o),   64'(b.param));
        check("beat_source",  64'(tl_a_source_o),  64'(b.source));
        check("beat_address", tl_a_address_o,      b.address);
      end
    end
  end

  // Bounded run time
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [2:0]  rr_op   [5];
  logic [5:0]  rr_src  [5];
  logic [63:0] rr_addr [5];
  logic [3:0]  rr_rdy  [5];

  initial begin
    // Hand-computed order for all-valid rotation: 0,1,2,3,0
    rr_op   = '{TL_A_PUT_FULL_DATA, TL_A_GET, TL_A_ACQUIRE_BLOCK, TL_A_ACQUIRE_PERM, TL_A_PUT_FULL_DATA};
    rr_src  = '{6'h01, 6'h12, 6'h23, 6'h34, 6'h01};
    rr_addr = '{64'h2000, 64'h2040, 64'h2080, 64'h20C0, 64'h2000};
    rr_rdy  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    // ---------------- reset ----------------
    core_a_valid_i = 4'b1111;
    tick();
    #1;
    check("rst_ready", 64'(core_a_ready_o), 64'h0);
    tick();
    check("rst_valid",   64'(tl_a_valid_o),   64'h0);
    check("rst_opcode",  64'(tl_a_opcode_o),  64'h0);
    check("rst_param",   64'(tl_a_param_o),   64'h0);
    check("rst_source",  64'(tl_a_source_o),  64'h0);
    check("rst_address", tl_a_address_o,      64'h0);
    rst_i          = 1'b0;
    core_a_valid_i = 4'b0000;
    tl_a_ready_i   = 1'b1;
    #1;
    check("idle_ready", 64'(core_a_ready_o), 64'h0);
    tick();

    // ---------------- single request ----------------
    drive_core(2, TL_A_GET, 3'd0, 4'h5, 64'h1000);
    core_a_valid_i = 4'b0100;
    #1;
    check("single_ready", 64'(core_a_ready_o), 64'b0100);
    push_exp(TL_A_GET, 3'd0, 6'h25, 64'h1000);
    tick();
    core_a_valid_i = 4'b0000;
    #1;
    check("single_latency", 64'(tl_a_valid_o), 64'h1);
    tick();
    #1;
    check("single_drain", 64'(tl_a_valid_o), 64'h0);

    // pointer back to 0
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;

    // ---------------- all cores, full throughput ----------------
    drive_core(0, TL_A_PUT_FULL_DATA, 3'd0, 4'h1, 64'h2000);
    drive_core(1, TL_A_GET,           3'd1, 4'h2, 64'h2040);
    drive_core(2, TL_A_ACQUIRE_BLOCK, 3'd2, 4'h3, 64'h2080);
    drive_core(3, TL_A_ACQUIRE_PERM,  3'd3, 4'h4, 64'h20C0);
    core_a_valid_i = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      #1;
      check("rr_ready", 64'(core_a_ready_o), 64'(rr_rdy[c]));
      check("rr_no_bubble", 64'(tl_a_valid_o), (c > 0) ? 64'h1 : 64'h0);
      push_exp(rr_op[c], 3'(c % 4), rr_src[c], rr_addr[c]);
      tick();
    end
    core_a_valid_i = 4'b0000;
    #1;
    check("rr_last_valid", 64'(tl_a_valid_o), 64'h1);
    tick();
    #1;
    check("rr_drain", 64'(tl_a_valid_o), 64'h0);

    // ---------------- backpressure (pointer now 1) ----------------
    drive_core(1, TL_A_GET, 3'd1, 4'h9, 64'hA000);
    core_a_valid_i = 4'b0010;
    #1;
    check("bp_first_ready", 64'(core_a_ready_o), 64'b0010);
    push_exp(TL_A_GET, 3'd1, 6'h19, 64'hA000);
    tick();
    tl_a_ready_i = 1'b0;
    drive_core(1, TL_A_PUT_FULL_DATA, 3'd0, 4'h3, 64'hB000);
    for (int c = 0; c < 5; c++) begin
      #1;
      check("bp_ready",   64'(core_a_ready_o), 64'h0);
      check("bp_valid",   64'(tl_a_valid_o),   64'h1);
      check("bp_source",  64'(tl_a_source_o),  64'h19);
      check("bp_address", tl_a_address_o,      64'hA000);
      tick();
    end
    tl_a_ready_i = 1'b1;
    #1;
    check("bp_release_ready", 64'(core_a_ready_o), 64'b0010);
    push_exp(TL_A_PUT_FULL_DATA, 3'd0, 6'h13, 64'hB000);
    tick();
    core_a_valid_i = 4'b0000;
    #1;
    check("bp_second_valid", 64'(tl_a_valid_o), 64'h1);
    tick();
    #1;
    check("bp_drain", 64'(tl_a_valid_o), 64'h0);

    // ---------------- fairness ----------------
    rst_i = 1'b1;
    tick();
    rst_i        = 1'b0;
    tl_a_ready_i = 1'b0;
    drive_core(0, TL_A_ACQUIRE_BLOCK, 3'd2, 4'h7, 64'hC000);
    core_a_valid_i = 4'b0001;
    #1;
    check("empty_ready_indep", 64'(core_a_ready_o), 64'b0001);
    push_exp(TL_A_ACQUIRE_BLOCK, 3'd2, 6'h07, 64'hC000);
    tick();
    drive_core(3, TL_A_ACQUIRE_PERM, 3'd1, 4'hE, 64'hD000);
    core_a_valid_i = 4'b1001;
    tl_a_ready_i   = 1'b1;
    #1;
    check("fair_first", 64'(core_a_ready_o), 64'b1000);
    push_exp(TL_A_ACQUIRE_PERM, 3'd1, 6'h3E, 64'hD000);
    tick();
    #1;
    check("fair_second", 64'(core_a_ready_o), 64'b0001);
    push_exp(TL_A_ACQUIRE_BLOCK, 3'd2, 6'h07, 64'hC000);
    tick();
    core_a_valid_i = 4'b0000;
    #1;
    tick();
    #1;
    check("fair_drain", 64'(tl_a_valid_o), 64'h0);

    // ---------------- reset mid-transfer ----------------
    drive_core(2, TL_A_GET, 3'd0, 4'hA, 64'hE000);
    core_a_valid_i = 4'b0100;
    #1;
    check("rm_load_ready", 64'(core_a_ready_o), 64'b0100);
    tick();
    tl_a_ready_i   = 1'b0;
    core_a_valid_i = 4'b0000;
    #1;
    check("rm_loaded", 64'(tl_a_valid_o), 64'h1);
    tick();
    rst_i          = 1'b1;
    core_a_valid_i = 4'b1111;
    #1;
    check("rm_rst_ready", 64'(core_a_ready_o), 64'h0);
    tick();
    #1;
    check("rm_flush_valid", 64'(tl_a_valid_o),   64'h0);
    check("rm_rst_ready2",  64'(core_a_ready_o), 64'h0);
    tick();
    rst_i        = 1'b0;
    tl_a_ready_i = 1'b1;
    #1;
    check("rm_post_grant", 64'(core_a_ready_o), 64'b0001);
    push_exp(TL_A_ACQUIRE_BLOCK, 3'd2, 6'h07, 64'hC000);
    tick();
    core_a_valid_i = 4'b0000;
    #1;
    tick();
    #1;
    check("final_idle", 64'(tl_a_valid_o), 64'h0);
    check("scoreboard_empty", 64'(exp_q.size()), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_rv64g_l2_a_arbiter
`default_nettype wire
